// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-subset core with a single unified memory port.
// A Moore control FSM sequences fetch, decode, execute, memory and
// write-back over a shared datapath (PC, IR, MDR, A, B, ALUOut, GPRs).
// The memory port holds each request stable until mem_ready.
// Build option: define MIPS_TRAP_EN to make unknown instructions halt in
// a TRAP state with trap=1; left undefined, they retire as a NOP.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | read instruction at pc, wait for mem_ready, pc += 4
// DECODE    | latch A/B, precompute branch target, dispatch on opcode
// EXEC_R    | ALUOut <= A op B
// EXEC_I    | ALUOut <= A + sext(imm) for addi
// MEM_ADR   | ALUOut <= A + sext(imm) for lw/sw
// MEM_RD    | read at ALUOut, wait for mem_ready, MDR <= data
// MEM_WR    | write B at ALUOut, wait for mem_ready, retire
// WB_R      | rd <= ALUOut, retire
// WB_I      | rt <= ALUOut, retire
// WB_MEM    | rt <= MDR, retire
// BRANCH    | beq: pc <= ALUOut when A == B, retire
// JUMP      | j/jal/jr pc update (jal also links $31), retire
// TRAP      | illegal instruction, frozen until reset (MIPS_TRAP_EN only)

module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32,
    parameter int          ADR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADR_WIDTH-1:0] mem_adr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_ready,
    output logic [31:0]          pc,
    output logic                 retire,
    output logic                 trap
);

    localparam int RW = $clog2(REG_COUNT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Link register index; truncates to the top GPR on reduced register files.
    localparam logic [RW-1:0] RA_IDX = '1;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t        state;
    logic [31:0]   pc_q;
    logic [31:0]   ir;
    logic [31:0]   mdr;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   alu_out;
    logic          rd_q;
    logic          wr_q;

    logic [31:0]   rf [REG_COUNT];

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [31:0]   imm_sext;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;
    logic [31:0]   alu_res;
    logic [31:0]   adr_src;

    state_t        dec_state;
    logic          dec_known;

    logic          rf_we;
    logic [RW-1:0] rf_wa;
    logic [31:0]   rf_wd;
    logic          rf_wen;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign rs_idx   = ir[21 +: RW];
    assign rt_idx   = ir[16 +: RW];
    assign rd_idx   = ir[11 +: RW];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    // $0 is hardwired to zero regardless of what the array holds.
    assign rs_val = (rs_idx == '0) ? 32'h0 : rf[rs_idx];
    assign rt_val = (rt_idx == '0) ? 32'h0 : rf[rt_idx];

    // R-type ALU; slt compares as signed, everything wraps.
    always_comb begin
        alu_res = a_q + b_q;
        case (funct)
            FN_ADD:  alu_res = a_q + b_q;
            FN_SUB:  alu_res = a_q - b_q;
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_SLT:  alu_res = {31'h0, ($signed(a_q) < $signed(b_q))};
            default: alu_res = a_q + b_q;
        endcase
    end

    // Opcode/funct dispatch used when leaving DECODE.
    always_comb begin
        dec_known = 1'b1;
        dec_state = S_FETCH;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT) begin
                    dec_state = S_EXEC_R;
                end else if (funct == FN_JR) begin
                    dec_state = S_JUMP;
                end else begin
                    dec_known = 1'b0;
                end
            end
            OP_ADDI:       dec_state = S_EXEC_I;
            OP_LW, OP_SW:  dec_state = S_MEM_ADR;
            OP_BEQ:        dec_state = S_BRANCH;
            OP_J, OP_JAL:  dec_state = S_JUMP;
            default:       dec_known = 1'b0;
        endcase
        if (!dec_known) begin
`ifdef MIPS_TRAP_EN
            dec_state = S_TRAP;
`else
            dec_state = S_FETCH;
`endif
        end
    end

    // Control FSM and datapath registers; rd_q/wr_q are the registered
    // request strobes and track entry into FETCH/MEM_RD and MEM_WR.
`ifdef MIPS_TRAP_EN
    logic trap_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc_q    <= RESET_PC;
            ir      <= 32'h0;
            mdr     <= 32'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            alu_out <= 32'h0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
`ifdef MIPS_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc_q  <= pc_q + 32'd4;
                        rd_q  <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rs_val;
                    b_q     <= rt_val;
                    alu_out <= pc_q + (imm_sext << 2);
                    state   <= dec_state;
                    if (dec_state == S_FETCH) begin
                        rd_q <= 1'b1;
                    end
`ifdef MIPS_TRAP_EN
                    if (dec_state == S_TRAP) begin
                        trap_q <= 1'b1;
                    end
`endif
                end
                S_EXEC_R: begin
                    alu_out <= alu_res;
                    state   <= S_WB_R;
                end
                S_EXEC_I: begin
                    alu_out <= a_q + imm_sext;
                    state   <= S_WB_I;
                end
                S_MEM_ADR: begin
                    alu_out <= a_q + imm_sext;
                    if (op == OP_LW) begin
                        rd_q  <= 1'b1;
                        state <= S_MEM_RD;
                    end else begin
                        wr_q  <= 1'b1;
                        state <= S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ready) begin
                        mdr   <= mem_rdata;
                        rd_q  <= 1'b0;
                        state <= S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        wr_q  <= 1'b0;
                        rd_q  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM: begin
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_BRANCH: begin
                    if (a_q == b_q) begin
                        pc_q <= alu_out;
                    end
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_JUMP: begin
                    if (op == OP_RTYPE) begin
                        pc_q <= a_q;
                    end else begin
                        pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
                    end
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    rd_q  <= 1'b1;
                    wr_q  <= 1'b0;
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Register-file write port selection for the write-back states and jal.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd_idx;
        rf_wd = alu_out;
        case (state)
            S_WB_R: begin
                rf_we = 1'b1;
                rf_wa = rd_idx;
            end
            S_WB_I: begin
                rf_we = 1'b1;
                rf_wa = rt_idx;
            end
            S_WB_MEM: begin
                rf_we = 1'b1;
                rf_wa = rt_idx;
                rf_wd = mdr;
            end
            S_JUMP: begin
                rf_we = (op == OP_JAL);
                rf_wa = RA_IDX;
                rf_wd = pc_q;
            end
            default: rf_we = 1'b0;
        endcase
    end

    // Writes to $0 are dropped and reset suppresses any pending write-back.
    assign rf_wen = rf_we && !rst && (rf_wa != '0);

    // General-purpose register array.
    always_ff @(posedge clk) begin
        if (rf_wen) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    // Data accesses use ALUOut, fetches use pc; low address bits forced to 0.
    assign adr_src   = (state == S_MEM_RD || state == S_MEM_WR) ? alu_out : pc_q;
    assign mem_adr   = {adr_src[ADR_WIDTH-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign mem_read  = rd_q && !rst;
    assign mem_write = wr_q && !rst;
    assign pc        = pc_q;

    // Retire pulses in the last cycle of each instruction.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR:                                   retire = mem_ready;
`ifndef MIPS_TRAP_EN
            S_DECODE:                                   retire = !dec_known;
`endif
            default:                                    retire = 1'b0;
        endcase
        if (rst) begin
            retire = 1'b0;
        end
    end

`ifdef MIPS_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Shift amount and the forced-zero address bits are intentionally unused.
    logic unused_bits;
    assign unused_bits = &{1'b0, ir[10:6], adr_src[1:0], dec_known};

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Testbench for mips_multi_cycle: a bench-owned word memory with
// programmable wait states, a scoreboard of expected stores, and
// cycle-exact checks on pc, retire count and the request strobes.
// Both MIPS_TRAP_EN builds are covered by the same file.

module tb_mips_multi_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [31:0] pc;
    logic        retire;
    logic        trap;

    always #5 clk = ~clk;

    mips_multi_cycle #(
        .RESET_PC (32'h0000_0100),
        .REG_COUNT(32),
        .ADR_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_adr  (mem_adr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_ready(mem_ready),
        .pc       (pc),
        .retire   (retire),
        .trap     (trap)
    );

    logic [31:0] mem [1024];
    assign mem_rdata = mem[mem_adr[11:2]];

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          retire_cnt = 0;
    int          stall_left = 0;
    int          rd_hits    = 0;
    logic [31:0] stall_adr  = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic put(input logic [31:0] adr, input logic [31:0] instr);
        mem[adr[11:2]] = instr;
    endtask

    // sw $rt, off($0), with the store the core must produce queued up front.
    task automatic put_sw(input logic [31:0] adr, input logic [4:0] rt,
                          input logic [15:0] off, input logic [31:0] data);
        wr_t e;
        put(adr, i_op(6'h2B, 5'd0, rt, off));
        e.adr  = {16'h0, off};
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Per-cycle work at the falling edge: choose mem_ready, then monitor.
    task automatic settle();
        wr_t e;
        if ((mem_read || mem_write) && mem_adr == stall_adr && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        #1;
        check_val("rd_wr_excl", {31'h0, mem_read & mem_write}, 32'h0);
        if (retire) retire_cnt++;
        if (mem_read && mem_adr == 32'h80) rd_hits++;
        if (mem_write && mem_ready) begin
            check_val("sb_write_expected", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("wr_adr", mem_adr, e.adr);
                check_val("wr_data", mem_wdata, e.data);
            end
            mem[mem_adr[11:2]] = mem_wdata;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst       = 1'b1;
        mem_ready = 1'b1;

        put(32'h100, i_op(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, i_op(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h108, r_op(5'd1, 5'd2, 5'd3, 6'h20));
        put_sw(32'h10C, 5'd3, 16'h40, 32'd12);
        put(32'h110, i_op(6'h23, 5'd0, 5'd4, 16'h80));
        put_sw(32'h114, 5'd4, 16'h44, 32'hDEAD_BEEF);
        put(32'h118, i_op(6'h08, 5'd0, 5'd5, 16'hFFFD));
        put(32'h11C, r_op(5'd1, 5'd5, 5'd6, 6'h22));
        put(32'h120, r_op(5'd3, 5'd2, 5'd7, 6'h24));
        put(32'h124, r_op(5'd1, 5'd2, 5'd8, 6'h25));
        put(32'h128, r_op(5'd5, 5'd1, 5'd9, 6'h2A));
        put(32'h12C, r_op(5'd1, 5'd5, 5'd10, 6'h2A));
        put_sw(32'h130, 5'd6, 16'h50, 32'd8);
        put_sw(32'h134, 5'd7, 16'h54, 32'd4);
        put_sw(32'h138, 5'd8, 16'h58, 32'd7);
        put_sw(32'h13C, 5'd9, 16'h5C, 32'd1);
        put_sw(32'h140, 5'd10, 16'h60, 32'd0);
        put(32'h144, i_op(6'h08, 5'd0, 5'd0, 16'd9));
        put_sw(32'h148, 5'd0, 16'h64, 32'd0);
        put(32'h14C, j_op(6'h02, 26'h4));
        put(32'h010, i_op(6'h04, 5'd1, 5'd1, 16'hFFFF));
        put(32'h014, j_op(6'h02, 26'h8));
        put(32'h020, j_op(6'h03, 26'h60));
        put_sw(32'h180, 5'd31, 16'h70, 32'h24);
        put(32'h184, r_op(5'd31, 5'd0, 5'd0, 6'h08));
        put(32'h024, {6'h3F, 26'h0});
`ifndef MIPS_TRAP_EN
        put_sw(32'h028, 5'd1, 16'h74, 32'd5);
`endif
        mem[32'h80 >> 2] = 32'hDEAD_BEEF;

        @(negedge clk);
        settle();
        cycle();
        cycle();
        check_val("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check_val("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check_val("rst_retire", {31'h0, retire}, 32'h0);
        check_val("rst_pc", pc, 32'h100);
        check_val("rst_trap", {31'h0, trap}, 32'h0);

        rst = 1'b0;
        settle();
        check_val("first_fetch_rd", {31'h0, mem_read}, 32'h1);
        check_val("first_fetch_adr", mem_adr, 32'h100);
        cycle();
        check_val("pc_after_fetch", pc, 32'h104);
        repeat (14) cycle();
        check_val("retire_16cyc", retire_cnt, 32'd4);
        check_val("pc_16cyc", pc, 32'h110);

        stall_adr  = 32'h80;
        stall_left = 3;
        rd_hits    = 0;
        repeat (8) cycle();
        check_val("lw_retire_8cyc", retire_cnt, 32'd5);
        check_val("lw_adr_stable", rd_hits, 32'd4);

        repeat (59) cycle();
        check_val("alu_block_retire", retire_cnt, 32'd20);
        cycle();
        check_val("j_pc", pc, 32'h10);
        check_val("j_fetch_adr", mem_adr, 32'h10);
        repeat (2) cycle();
        check_val("beq_retire", retire_cnt, 32'd21);
        cycle();
        check_val("beq_taken_pc", pc, 32'h10);
        check_val("beq_taken_adr", mem_adr, 32'h10);
        put(32'h010, i_op(6'h04, 5'd1, 5'd2, 16'hFFFF));
        repeat (3) cycle();
        check_val("beq_not_taken_pc", pc, 32'h14);
        check_val("beq_not_taken_adr", mem_adr, 32'h14);

        repeat (3) cycle();
        check_val("j2_pc", pc, 32'h20);
        repeat (3) cycle();
        check_val("jal_pc", pc, 32'h180);
        repeat (4) cycle();
        repeat (3) cycle();
        check_val("jr_pc", pc, 32'h24);
        check_val("jr_retire", retire_cnt, 32'd26);

`ifdef MIPS_TRAP_EN
        repeat (2) cycle();
        check_val("trap_set", {31'h0, trap}, 32'h1);
        check_val("trap_no_read", {31'h0, mem_read}, 32'h0);
        repeat (4) begin
            cycle();
            check_val("trap_hold_read", {31'h0, mem_read}, 32'h0);
            check_val("trap_hold_retire", {31'h0, retire}, 32'h0);
            check_val("trap_hold_pc", pc, 32'h28);
        end
        check_val("trap_retire_cnt", retire_cnt, 32'd26);
`else
        repeat (2) cycle();
        check_val("nop_fetch_adr", mem_adr, 32'h28);
        check_val("nop_fetch_rd", {31'h0, mem_read}, 32'h1);
        check_val("nop_retire", retire_cnt, 32'd27);
        check_val("nop_trap", {31'h0, trap}, 32'h0);
        repeat (4) cycle();
        check_val("post_nop_adr", mem_adr, 32'h2C);
        check_val("post_nop_retire", retire_cnt, 32'd28);
`endif

        rst = 1'b1;
        settle();
        check_val("rst2_gate_rd", {31'h0, mem_read}, 32'h0);
        cycle();
        check_val("rst2_pc", pc, 32'h100);
        check_val("rst2_trap", {31'h0, trap}, 32'h0);
        put(32'h100, i_op(6'h2B, 5'd0, 5'd3, 16'h78));
        stall_adr  = 32'h78;
        stall_left = 100;
        rst = 1'b0;
        settle();
        repeat (3) cycle();
        check_val("abort_wr_req", {31'h0, mem_write}, 32'h1);
        check_val("abort_wr_adr", mem_adr, 32'h78);
        check_val("abort_wr_data", mem_wdata, 32'd12);
        repeat (2) cycle();
        check_val("abort_adr_stable", mem_adr, 32'h78);
        rst = 1'b1;
        settle();
        check_val("abort_gate_wr", {31'h0, mem_write}, 32'h0);
        cycle();
        rst = 1'b0;
        settle();
        check_val("abort_no_write", {31'h0, mem_write}, 32'h0);
        check_val("abort_pc", pc, 32'h100);
        check_val("abort_fetch", {31'h0, mem_read}, 32'h1);
        check_val("abort_mem_untouched", mem[32'h78 >> 2], 32'h0);
        check_val("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
